// File: rtl/controle_elevador.sv
// controle_elevador: elevator car controller.
// Latches floor calls and serves them in SCAN order, which keeps the car moving
// in its current direction while calls remain ahead of it. It times the travel
// between floors and the door dwell, and decodes the Su/De/PA/PF flags and the
// current floor from registered state only.
// Optional feature: define EMERGENCIA_EN to add the emerg input. While emerg is
// high, all calls are dropped, the car stops at the next floor and the door is
// held open.
module controle_elevador #(
    parameter int NUM_ANDARES  = 4,
    parameter int TEMPO_VIAGEM = 50_000_000,
    parameter int TEMPO_PORTA  = 150_000_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_ANDARES-1:0]         chamada,
`ifdef EMERGENCIA_EN
    input  logic                           emerg,
`endif
    output logic [$clog2(NUM_ANDARES)-1:0] andar_atual,
    output logic                           Su,
    output logic                           De,
    output logic                           PA,
    output logic                           PF
);

    localparam int              AW           = $clog2(NUM_ANDARES);
    localparam logic [AW-1:0]   ANDAR_MAX    = AW'(NUM_ANDARES - 1);
    // The timer counts down to zero and the state ends on the edge after zero,
    // so loading N-1 gives exactly N cycles in the state.
    localparam logic [31:0]     CARGA_VIAGEM = 32'(TEMPO_VIAGEM - 1);
    localparam logic [31:0]     CARGA_PORTA  = 32'(TEMPO_PORTA - 1);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBINDO  = 2'd1,
        DESCENDO = 2'd2,
        PORTA    = 2'd3
    } estado_t;

    estado_t                estado, estado_n;
    logic [AW-1:0]          andar, andar_n;
    logic [NUM_ANDARES-1:0] pend, pend_n;
    logic                   dir, dir_n;     // 1 = up, 0 = down
    logic [31:0]            timer, timer_n;

    // Is any call pending on a floor strictly above f?
    function automatic logic ha_acima(input logic [NUM_ANDARES-1:0] p,
                                      input logic [AW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++) begin
            if (p[i] && (AW'(i) > f)) r = 1'b1;
        end
        return r;
    endfunction

    // Is any call pending on a floor strictly below f?
    function automatic logic ha_abaixo(input logic [NUM_ANDARES-1:0] p,
                                       input logic [AW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++) begin
            if (p[i] && (AW'(i) < f)) r = 1'b1;
        end
        return r;
    endfunction

    // State register, floor, pending calls, direction and timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= PARADO;
            andar  <= '0;
            pend   <= '0;
            dir    <= 1'b1;
            timer  <= '0;
        end else begin
            estado <= estado_n;
            andar  <= andar_n;
            pend   <= pend_n;
            dir    <= dir_n;
            timer  <= timer_n;
        end
    end

    // Next-state logic. Decisions use the registered pend, so a call latched
    // on one edge is acted upon on the following edge.
    always_comb begin
        estado_n = estado;
        andar_n  = andar;
        dir_n    = dir;
        timer_n  = timer;
        pend_n   = pend | chamada;

        case (estado)
            PARADO: begin
                if (pend[andar]) begin
                    estado_n      = PORTA;
                    timer_n       = CARGA_PORTA;
                    pend_n[andar] = 1'b0;
                end else if (ha_acima(pend, andar) &&
                             (dir || !ha_abaixo(pend, andar))) begin
                    estado_n = SUBINDO;
                    dir_n    = 1'b1;
                    timer_n  = CARGA_VIAGEM;
                end else if (ha_abaixo(pend, andar)) begin
                    estado_n = DESCENDO;
                    dir_n    = 1'b0;
                    timer_n  = CARGA_VIAGEM;
                end
            end

            SUBINDO: begin
                // The top floor has nothing above it; never step past it.
                if (andar == ANDAR_MAX) begin
                    estado_n = PARADO;
                end else if (timer != '0) begin
                    timer_n = timer - 32'd1;
                end else begin
                    andar_n = andar + AW'(1);
                    if (pend[andar_n]) begin
                        estado_n        = PORTA;
                        timer_n         = CARGA_PORTA;
                        pend_n[andar_n] = 1'b0;
                    end else if (ha_acima(pend, andar_n)) begin
                        timer_n = CARGA_VIAGEM;
                    end else begin
                        estado_n = PARADO;
                    end
                end
            end

            DESCENDO: begin
                // Floor 0 has nothing below it; never step past it.
                if (andar == '0) begin
                    estado_n = PARADO;
                end else if (timer != '0) begin
                    timer_n = timer - 32'd1;
                end else begin
                    andar_n = andar - AW'(1);
                    if (pend[andar_n]) begin
                        estado_n        = PORTA;
                        timer_n         = CARGA_PORTA;
                        pend_n[andar_n] = 1'b0;
                    end else if (ha_abaixo(pend, andar_n)) begin
                        timer_n = CARGA_VIAGEM;
                    end else begin
                        estado_n = PARADO;
                    end
                end
            end

            PORTA: begin
                // A call for this floor is served by the open door: it never
                // stays pending, and it restarts the full dwell.
                pend_n[andar] = 1'b0;
                if (chamada[andar]) begin
                    timer_n = CARGA_PORTA;
                end else if (timer != '0) begin
                    timer_n = timer - 32'd1;
                end else begin
                    estado_n = PARADO;
                end
            end

            default: begin
                estado_n = PARADO;
            end
        endcase

`ifdef EMERGENCIA_EN
        // Emergency overrides: drop all calls, open the door at the current
        // or the next floor, and hold the dwell timer at its full value.
        if (emerg) begin
            pend_n = '0;
            case (estado)
                PARADO: begin
                    estado_n = PORTA;
                    timer_n  = CARGA_PORTA;
                    dir_n    = dir;
                end
                SUBINDO, DESCENDO: begin
                    if (andar_n != andar) begin
                        estado_n = PORTA;
                        timer_n  = CARGA_PORTA;
                    end
                end
                PORTA: begin
                    estado_n = PORTA;
                    timer_n  = CARGA_PORTA;
                end
                default: begin
                    estado_n = PARADO;
                end
            endcase
        end
`endif
    end

    // Output decode from registered state only.
    always_comb begin
        andar_atual = andar;
        Su          = (estado == SUBINDO);
        De          = (estado == DESCENDO);
        PA          = (estado == PORTA);
        PF          = (estado != PORTA);
    end

endmodule

// File: tb/tb_controle_elevador.sv
// Bench for controle_elevador (NUM_ANDARES=4, TEMPO_VIAGEM=4, TEMPO_PORTA=6).
// A behavioural car model tracks floor, pending calls and the remaining time
// of the current activity; every cycle out of reset the DUT outputs are
// compared with it. Directed scenarios add literal timing expectations.
module tb_controle_elevador;

    localparam int N  = 4;
    localparam int TV = 4;
    localparam int TP = 6;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] chamada;
    logic [1:0]   andar_atual;
    logic         Su, De, PA, PF;

    int n_pass  = 0;
    int n_total = 0;

    controle_elevador #(
        .NUM_ANDARES  (N),
        .TEMPO_VIAGEM (TV),
        .TEMPO_PORTA  (TP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chamada     (chamada),
        .andar_atual (andar_atual),
        .Su          (Su),
        .De          (De),
        .PA          (PA),
        .PF          (PF)
    );

    // Clock
    always #5 clk = ~clk;

    // Generic comparison with pass/total accounting.
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int       m_mode  = M_IDLE;
    int       m_floor = 0;
    bit       m_up    = 1'b1;
    bit [N-1:0] m_pend = '0;
    int       m_left  = 0;   // cycles still to spend in the current activity

    function automatic bit any_above(input bit [N-1:0] p, input int f);
        for (int j = 0; j < N; j++) if (p[j] && j > f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input bit [N-1:0] p, input int f);
        for (int j = 0; j < N; j++) if (p[j] && j < f) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit [N-1:0] ch);
        bit [N-1:0] seen;
        bit [N-1:0] nxt;
        seen = m_pend;
        nxt  = m_pend | ch;
        case (m_mode)
            M_IDLE: begin
                if (seen[m_floor]) begin
                    m_mode = M_DOOR; m_left = TP; nxt[m_floor] = 1'b0;
                end else if (any_above(seen, m_floor) && (m_up || !any_below(seen, m_floor))) begin
                    m_mode = M_UP; m_up = 1'b1; m_left = TV;
                end else if (any_below(seen, m_floor)) begin
                    m_mode = M_DOWN; m_up = 1'b0; m_left = TV;
                end
            end
            M_UP, M_DOWN: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
                    if (seen[m_floor]) begin
                        m_mode = M_DOOR; m_left = TP; nxt[m_floor] = 1'b0;
                    end else if ((m_mode == M_UP) ? any_above(seen, m_floor)
                                                  : any_below(seen, m_floor)) begin
                        m_left = TV;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                nxt[m_floor] = 1'b0;
                if (ch[m_floor]) m_left = TP;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
        m_pend = nxt;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_floor = 0; m_up = 1'b1; m_pend = '0; m_left = 0;
        end else begin
            model_step(chamada);
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        int act_v;
        int exp_v;
        if (rst_n === 1'b1) begin
            act_v = {26'd0, andar_atual, Su, De, PA, PF};
            exp_v = (m_floor * 16) + ((m_mode == M_UP) ? 8 : 0) + ((m_mode == M_DOWN) ? 4 : 0)
                  + ((m_mode == M_DOOR) ? 2 : 0) + ((m_mode != M_DOOR) ? 1 : 0);
            chk("outputs_vs_model", act_v, exp_v);
        end
    end

    // ---------------- driver / history ----------------
    int su_h[64], de_h[64], pa_h[64], fl_h[64];

    // Starting at a falling edge: runs n cycles, drives optional one-cycle
    // pulses at step p1/p2 (step 0 = now) and records outputs each cycle.
    task automatic watch(input int n, input int p1, input logic [N-1:0] v1,
                         input int p2, input logic [N-1:0] v2);
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                su_h[i] = int'(Su); de_h[i] = int'(De);
                pa_h[i] = int'(PA); fl_h[i] = int'(andar_atual);
            end
            if (i == p1) chamada = v1;
            else if (i == p2) chamada = v2;
            else chamada = '0;
        end
    endtask

    // sel: 0 = Su, 1 = De, 2 = PA
    function automatic int count_of(input int sel, input int n);
        int c;
        c = 0;
        for (int i = 1; i <= n; i++)
            c += (sel == 0) ? su_h[i] : (sel == 1) ? de_h[i] : pa_h[i];
        return c;
    endfunction

    function automatic int first_of(input int sel, input int n);
        for (int i = 1; i <= n; i++)
            if (((sel == 0) ? su_h[i] : (sel == 1) ? de_h[i] : pa_h[i]) == 1) return i;
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        chamada = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_Su", int'(Su), 0);
        chk("rst_De", int'(De), 0);
        chk("rst_PA", int'(PA), 0);
        chk("rst_PF", int'(PF), 1);
        chk("rst_andar", int'(andar_atual), 0);
        rst_n = 1'b1;

        // Idle with no calls
        watch(20, -1, '0, -1, '0);
        chk("idle_moves", count_of(0, 20) + count_of(1, 20) + count_of(2, 20), 0);
        chk("idle_andar", fl_h[20], 0);

        // Call floor 2 from floor 0
        watch(20, 0, 4'b0100, -1, '0);
        chk("t2_su_first", first_of(0, 20), 2);
        chk("t2_su_count", count_of(0, 20), 8);
        chk("t2_andar_mid", fl_h[6], 1);
        chk("t2_pa_first", first_of(2, 20), 10);
        chk("t2_pa_count", count_of(2, 20), 6);
        chk("t2_andar_door", fl_h[10], 2);

        // From floor 2 heading up, calls at 3 and 0 together
        watch(40, 0, 4'b1001, -1, '0);
        chk("t3_su_first", first_of(0, 40), 2);
        chk("t3_su_count", count_of(0, 40), 4);
        chk("t3_de_first", first_of(1, 40), 13);
        chk("t3_de_count", count_of(1, 40), 12);
        chk("t3_pa_count", count_of(2, 40), 12);
        chk("t3_andar_end", fl_h[40], 0);

        // Door at floor 1 re-called three cycles into the dwell
        watch(30, 0, 4'b0010, 8, 4'b0010);
        chk("t4_pa_first", first_of(2, 30), 6);
        chk("t4_andar_door", fl_h[6], 1);
        chk("t4_pa_count", count_of(2, 30), 9);
        chk("t4_pa_last", pa_h[14] * 10 + pa_h[15], 10);

        // Async reset while moving up from floor 1
        watch(7, 0, 4'b1000, -1, '0);
        chk("t5_pre_andar", fl_h[7], 2);
        chk("t5_pre_Su", su_h[7], 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_Su", int'(Su), 0);
        chk("t5_async_andar", int'(andar_atual), 0);
        chk("t5_async_PF", int'(PF), 1);
        @(negedge clk);
        rst_n = 1'b1;
        watch(20, -1, '0, -1, '0);
        chk("t5_after_moves", count_of(0, 20) + count_of(1, 20) + count_of(2, 20), 0);
        chk("t5_after_andar", fl_h[20], 0);

        // Random traffic, with one asynchronous reset in the middle
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) chamada = 4'($urandom_range(1, 15));
            else chamada = '0;
            if (c == 700) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n   = 1'b1;
                chamada = '0;
            end
        end
        @(negedge clk);
        chamada = '0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
